// File: rtl/fp_normalizer.sv
// Post-add normalizer: turns a raw {carry, hidden, fraction} significand sum back into a normalized float.
// Define FP_NORM_FASTPATH_EN for the single-cycle leading-zero shifter; otherwise one bit is shifted per cycle.
package float_pkg;
   localparam int EXPONENT_BITS = 8;
   localparam int FRACTION_BITS = 23;

   typedef struct packed {
      logic                     sign;
      logic [EXPONENT_BITS-1:0] exponent;
      logic [FRACTION_BITS-1:0] fraction;
   } float;
endpackage

module fp_normalizer
   import float_pkg::*;
#(
   parameter int EXP_W  = EXPONENT_BITS,
   parameter int FRAC_W = FRACTION_BITS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exponent,
   input  logic [FRAC_W+1:0] in_sig,
   output logic              out_valid,
   input  logic              out_ready,
   output float              result,
   output logic              out_zero,
   output logic              out_overflow,
   output logic              out_underflow,
   output logic [1:0]        debug_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready is high only in IDLE; out_valid is high only in DONE, and result/flags hold until out_ready.
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [EXP_W-1:0] EXP_ALL  = '1;
   localparam logic [EXP_W-1:0] EXP_NEAR = EXP_ALL - EXP_ONE;

   state_t            state, state_nxt;
   logic              sign_q, sign_nxt;
   logic [EXP_W-1:0]  exp_q, exp_nxt;
   logic [FRAC_W+1:0] sig_q, sig_nxt;
   float              result_q, result_nxt;
   logic              zero_q, zero_nxt;
   logic              ovf_q, ovf_nxt;
   logic              unf_q, unf_nxt;

`ifdef FP_NORM_FASTPATH_EN
   logic [EXP_W-1:0]  lz;
   logic              found;
   logic [FRAC_W+1:0] shifted;

   // Leading zeros over {hidden, fraction}; only consulted when hidden is 0 and the sum is nonzero.
   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = FRAC_W; i >= 0; i--) begin
         if (!found) begin
            if (sig_q[i]) found = 1'b1;
            else          lz    = lz + EXP_ONE;
         end
      end
      shifted = sig_q << lz;
   end
`endif

   always_comb begin
      state_nxt  = state;
      sign_nxt   = sign_q;
      exp_nxt    = exp_q;
      sig_nxt    = sig_q;
      result_nxt = result_q;
      zero_nxt   = zero_q;
      ovf_nxt    = ovf_q;
      unf_nxt    = unf_q;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sign_nxt  = in_sign;
               exp_nxt   = in_exponent;
               sig_nxt   = in_sig;
               zero_nxt  = 1'b0;
               ovf_nxt   = 1'b0;
               unf_nxt   = 1'b0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (sig_q == '0) begin
               result_nxt = '0;
               zero_nxt   = 1'b1;
               state_nxt  = DONE;
            end else if (sig_q[FRAC_W+1]) begin
               // Carry-out: one right shift; saturate to infinity rather than wrap the exponent.
               result_nxt.sign = sign_q;
               if (exp_q >= EXP_NEAR) begin
                  result_nxt.exponent = EXP_ALL;
                  result_nxt.fraction = '0;
                  ovf_nxt             = 1'b1;
               end else begin
                  result_nxt.exponent = exp_q + EXP_ONE;
                  result_nxt.fraction = sig_q[FRAC_W:1];
               end
               state_nxt = DONE;
            end else if (sig_q[FRAC_W]) begin
               result_nxt.sign     = sign_q;
               result_nxt.exponent = exp_q;
               result_nxt.fraction = sig_q[FRAC_W-1:0];
               state_nxt           = DONE;
`ifdef FP_NORM_FASTPATH_EN
            end else if (exp_q <= lz) begin
               result_nxt      = '0;
               result_nxt.sign = sign_q;
               unf_nxt         = 1'b1;
               state_nxt       = DONE;
            end else begin
               result_nxt.sign     = sign_q;
               result_nxt.exponent = exp_q - lz;
               result_nxt.fraction = shifted[FRAC_W-1:0];
               state_nxt           = DONE;
            end
`else
            end else if (exp_q <= EXP_ONE) begin
               // No denormals: flush once the exponent cannot drop any further.
               result_nxt      = '0;
               result_nxt.sign = sign_q;
               unf_nxt         = 1'b1;
               state_nxt       = DONE;
            end else begin
               sig_nxt = sig_q << 1;
               exp_nxt = exp_q - EXP_ONE;
            end
`endif
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         sig_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         sign_q   <= sign_nxt;
         exp_q    <= exp_nxt;
         sig_q    <= sig_nxt;
         result_q <= result_nxt;
         zero_q   <= zero_nxt;
         ovf_q    <= ovf_nxt;
         unf_q    <= unf_nxt;
      end
   end

   assign in_ready      = (state == IDLE);
   assign out_valid     = (state == DONE);
   assign result        = result_q;
   assign out_zero      = zero_q;
   assign out_overflow  = ovf_q;
   assign out_underflow = unf_q;
   assign debug_state   = state;

endmodule

// File: tb/tb_fp_normalizer.sv
// Randomized bench for fp_normalizer (EXP_W=8, FRAC_W=23) against an arithmetic reference model.
// Latency is counted as edges after the accept edge until out_valid is seen high.
module tb_fp_normalizer;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [7:0]    in_exponent;
   logic [24:0]   in_sig;
   logic          out_valid;
   logic          out_ready;
   float_pkg::float result;
   logic          out_zero;
   logic          out_overflow;
   logic          out_underflow;
   logic [1:0]    debug_state;

   int n_checks = 0;
   int n_errors = 0;

   fp_normalizer dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exponent(in_exponent), .in_sig(in_sig),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_zero(out_zero),
      .out_overflow(out_overflow), .out_underflow(out_underflow),
      .debug_state(debug_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: locate the leading one, then apply carry / normalize / flush rules arithmetically.
   function automatic void model(input logic s, input logic [7:0] e, input logic [24:0] g,
                                 output logic [31:0] r, output logic z, output logic o,
                                 output logic u, output int cyc);
      int ei, p, k;
      logic [24:0] sh;
      r = '0; z = 1'b0; o = 1'b0; u = 1'b0; cyc = 1;
      ei = int'(e);
      if (g == 25'd0) begin
         z = 1'b1;
      end else if (g[24]) begin
         if (ei + 1 >= 255) begin
            r = {s, 8'hFF, 23'h0};
            o = 1'b1;
         end else begin
            r = {s, 8'(ei + 1), g[23:1]};
         end
      end else begin
         p = 0;
         for (int i = 0; i < 24; i++) if (g[i]) p = i;
         k = 23 - p;
         if (k == 0) begin
            r = {s, e, g[22:0]};
         end else if (ei - k < 1) begin
            r = {s, 31'h0};
            u = 1'b1;
`ifndef FP_NORM_FASTPATH_EN
            // One exponent step per cycle until it reaches 1, then the flush cycle.
            cyc = (ei <= 1) ? 1 : ei;
`endif
         end else begin
            sh = g << k;
            r  = {s, 8'(ei - k), sh[22:0]};
`ifndef FP_NORM_FASTPATH_EN
            cyc = k + 1;
`endif
         end
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_op(input logic s, input logic [7:0] e, input logic [24:0] g, input int stall);
      logic [31:0] er;
      logic ez, eo, eu;
      int ecyc, edges;
      model(s, e, g, er, ez, eo, eu, ecyc);
      check("in_ready_idle", in_ready, 1'b1);
      in_sign = s; in_exponent = e; in_sig = g; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("in_ready_busy", in_ready, 1'b0);
      edges = 0;
      while (!out_valid && edges < 100) begin
         tick();
         edges++;
      end
      check("latency", edges, ecyc);
      check("result", result, er);
      check("zero", out_zero, ez);
      check("overflow", out_overflow, eo);
      check("underflow", out_underflow, eu);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_sig = 25'($urandom);
         tick();
         check("stall_valid", out_valid, 1'b1);
         check("stall_result", result, er);
         check("stall_ready", in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("valid_drop", out_valid, 1'b0);
   endtask

   initial begin
      logic [24:0] g;
      logic [7:0]  e;
      int          kind;
      reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exponent = '0; in_sig = '0; out_ready = 1'b0;
      tick();
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 32'h0);
      check("rst_flags", {out_zero, out_overflow, out_underflow}, 3'b000);
      reset = 1'b0;
      tick();
      check("rst_in_ready", in_ready, 1'b1);

      run_op(1'b1, 8'h80, 25'h1000000, 0);
      run_op(1'b0, 8'h85, 25'h0200000, 0);
      run_op(1'b1, 8'h7F, 25'h0000000, 0);
      run_op(1'b0, 8'hFE, 25'h1800000, 0);
      run_op(1'b1, 8'hFF, 25'h1000001, 0);
      run_op(1'b0, 8'h03, 25'h0000001, 0);
      run_op(1'b0, 8'h19, 25'h0000001, 0);
      run_op(1'b1, 8'h02, 25'h0400000, 0);
      run_op(1'b0, 8'h00, 25'h0812345, 0);
      run_op(1'b1, 8'h40, 25'h0C00001, 5);

      // Reset while an operation is in flight: nothing may come out afterwards.
      in_sign = 1'b0; in_exponent = 8'h90; in_sig = 25'h0000010; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_result", result, 32'h0);
      for (int i = 0; i < 30; i++) begin
         tick();
         check("abort_quiet", out_valid, 1'b0);
      end

      for (int n = 0; n < 250; n++) begin
         kind = $urandom_range(0, 3);
         g = 25'($urandom);
         e = 8'($urandom);
         case (kind)
            1: g = g >> $urandom_range(1, 24);
            2: begin g = g >> $urandom_range(1, 24); e = 8'($urandom_range(0, 26)); end
            3: e = 8'($urandom_range(250, 255));
            default: ;
         endcase
         if ($urandom_range(0, 15) == 0) g = '0;
         run_op(1'($urandom), e, g, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
